alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter OP_W, default 5: width of ALU opcode field.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  stage can accept a request.
REQ-006 req_op  input  OP_W  ALU opcode.
REQ-007 req_oper_a  input  8  operand A, used when req_use_acc=0.
REQ-008 req_oper_b  input  8  operand B.
REQ-009 req_use_acc  input  1  1 = take operand A from internal accumulator.
REQ-010 req_acc_wr  input  1  1 = write ALU result to accumulator.
REQ-011 req_flag_wr  input  1  1 = write ALU flags to flag register.
REQ-012 alu_op / alu_oper_a / alu_oper_b  output  OP_W/8/8  registered operation driven to ALU.
REQ-013 alu_flag_carry / alu_flag_zero / alu_flag_neg / alu_flag_aux_carry  output  1 each  flag register bits driven to ALU.
REQ-014 alu_result  input  8  ALU combinational result.
REQ-015 alu_res_carry / alu_res_zero / alu_res_neg / alu_res_aux_carry  input  1 each  ALU output flags.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_result  output  8  captured ALU result.
REQ-019 rsp_flags  output  4  captured ALU flags {Z,N,H,C}.
REQ-020 acc  output  8  accumulator register.
REQ-021 flags  output  4  flag register {Z,N,H,C} (LR35902 F[7:4] order).

Function
REQ-022 FSM states IDLE, EXEC, RESP; encoding free.
REQ-023 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-024 IDLE: on req_valid&req_ready at edge N, latch req_op to alu_op, operand A (acc if req_use_acc else req_oper_a) to alu_oper_a, req_oper_b to alu_oper_b, latch req_acc_wr/req_flag_wr, go EXEC.
REQ-025 alu_flag_* SHALL equal the flag register at all times (flags of prior committed op).
REQ-026 EXEC lasts exactly one cycle; at its closing edge (N+1) capture alu_result to rsp_result and ALU flags to rsp_flags, go RESP.
REQ-027 At the same edge N+1: if latched acc_wr, acc <= alu_result; if latched flag_wr, flags <= {alu_res_zero,alu_res_neg,alu_res_aux_carry,alu_res_carry}; otherwise unchanged.
REQ-028 rsp_valid SHALL first be 1 in the cycle following edge N+1 (2-cycle latency); rsp_result/rsp_flags stable while rsp_valid=1.
REQ-029 RESP: go IDLE at edge where rsp_ready=1; hold RESP indefinitely while rsp_ready=0.
REQ-030 Peak throughput one operation per 3 cycles; no request accepted while EXEC or RESP.
REQ-031 Operand A taken from acc SHALL reflect all writebacks of previously completed ops (no hazard, since one op in flight).
REQ-032 alu_op/alu_oper_a/alu_oper_b SHALL hold their value outside EXEC until next accept.
REQ-033 req_* inputs while req_ready=0 SHALL be ignored.

Reset
REQ-034 rst=1 at an edge: state IDLE, acc=8'h00, flags=4'h0, rsp_result=8'h00, rsp_flags=4'h0, alu_op/alu_oper_a/alu_oper_b=0, rsp_valid=0.
REQ-035 rst during EXEC or RESP SHALL abort the op: no accumulator/flag writeback, no response; rst overrides simultaneous req_valid.
REQ-036 req_ready SHALL be 1 in first cycle after rst deasserts.

Verification
REQ-037 Reset then req ADD a=8'h3A b=8'hC6 use_acc=0 acc_wr=1 flag_wr=1, ALU returns 8'h00 Z=1 N=0 H=1 C=1 -> rsp_valid 2 cycles after accept, rsp_result=8'h00, rsp_flags=4'b1011, acc=8'h00, flags=4'b1011.
REQ-038 Next req use_acc=1 b=8'h01 while acc=8'h00 -> alu_oper_a=8'h00, alu_flag_carry=1, alu_flag_zero=1 during EXEC.
REQ-039 Req with acc_wr=0 flag_wr=1, ALU returns 8'h55 flags 4'b0100 -> acc unchanged, flags=4'b0100, rsp_result=8'h55.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result constant, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-041 Assert rst during EXEC of op with acc_wr=1, ALU result 8'hFF -> acc=8'h00, flags=4'h0, rsp_valid never asserted, req_ready=1 after rst release.
REQ-042 Random back-to-back requests with random rsp_ready vs reference model -> every accepted request yields exactly one response, in order, matching acc/flags model.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Brief    : Single-issue front end for a combinational 8-bit ALU. Accepts
//             one request at a time, registers the operation toward the ALU,
//             captures the result one cycle later, and writes it back to the
//             accumulator and flag register.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [7:0]      req_oper_a,
    input  logic [7:0]      req_oper_b,
    input  logic            req_use_acc,
    input  logic            req_acc_wr,
    input  logic            req_flag_wr,

    output logic [OP_W-1:0] alu_op,
    output logic [7:0]      alu_oper_a,
    output logic [7:0]      alu_oper_b,
    output logic            alu_flag_carry,
    output logic            alu_flag_zero,
    output logic            alu_flag_neg,
    output logic            alu_flag_aux_carry,
    input  logic [7:0]      alu_result,
    input  logic            alu_res_carry,
    input  logic            alu_res_zero,
    input  logic            alu_res_neg,
    input  logic            alu_res_aux_carry,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_result,
    output logic [3:0]      rsp_flags,

    output logic [7:0]      acc,
    output logic [3:0]      flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [OP_W-1:0] r_alu_op;
    logic [7:0]      r_alu_oper_a;
    logic [7:0]      r_alu_oper_b;
    logic            r_acc_wr;
    logic            r_flag_wr;
    logic [7:0]      r_acc;
    logic [3:0]      r_flags;
    logic [7:0]      r_rsp_result;
    logic [3:0]      r_rsp_flags;

    logic            w_accept;
    logic [7:0]      w_oper_a;
    logic [3:0]      w_alu_flags;

    // Only one op is ever in flight, so the accumulator is always current here.
    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_oper_a    = req_use_acc ? r_acc : req_oper_a;
    assign w_alu_flags = {alu_res_zero, alu_res_neg, alu_res_aux_carry, alu_res_carry};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC lasts one cycle, RESP until taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch the op on accept, capture and write back at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op     <= '0;
            r_alu_oper_a <= 8'h00;
            r_alu_oper_b <= 8'h00;
            r_acc_wr     <= 1'b0;
            r_flag_wr    <= 1'b0;
            r_acc        <= 8'h00;
            r_flags      <= 4'h0;
            r_rsp_result <= 8'h00;
            r_rsp_flags  <= 4'h0;
        end else begin
            if (w_accept) begin
                r_alu_op     <= req_op;
                r_alu_oper_a <= w_oper_a;
                r_alu_oper_b <= req_oper_b;
                r_acc_wr     <= req_acc_wr;
                r_flag_wr    <= req_flag_wr;
            end
            if (r_state == EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= w_alu_flags;
                if (r_acc_wr) begin
                    r_acc <= alu_result;
                end
                if (r_flag_wr) begin
                    r_flags <= w_alu_flags;
                end
            end
        end
    end

    assign req_ready          = (r_state == IDLE);
    assign rsp_valid          = (r_state == RESP);
    assign alu_op             = r_alu_op;
    assign alu_oper_a         = r_alu_oper_a;
    assign alu_oper_b         = r_alu_oper_b;
    assign alu_flag_zero      = r_flags[3];
    assign alu_flag_neg       = r_flags[2];
    assign alu_flag_aux_carry = r_flags[1];
    assign alu_flag_carry     = r_flags[0];
    assign rsp_result         = r_rsp_result;
    assign rsp_flags          = r_rsp_flags;
    assign acc                = r_acc;
    assign flags              = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Brief    : Self-checking bench for alu_issue_stage with a behavioural ALU,
//             directed scenarios and a randomized scoreboard phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int OP_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready;
    logic [OP_W-1:0] req_op;
    logic [7:0]      req_oper_a, req_oper_b;
    logic            req_use_acc, req_acc_wr, req_flag_wr;
    logic [OP_W-1:0] alu_op;
    logic [7:0]      alu_oper_a, alu_oper_b;
    logic            alu_flag_carry, alu_flag_zero, alu_flag_neg, alu_flag_aux_carry;
    logic [7:0]      alu_result;
    logic            alu_res_carry, alu_res_zero, alu_res_neg, alu_res_aux_carry;
    logic            rsp_valid, rsp_ready;
    logic [7:0]      rsp_result;
    logic [3:0]      rsp_flags;
    logic [7:0]      acc;
    logic [3:0]      flags;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state
    logic [7:0] m_acc;
    logic [3:0] m_flags;

    typedef struct {
        logic [7:0] res;
        logic [3:0] rfl;
        logic [7:0] acc;
        logic [3:0] fl;
    } exp_t;
    exp_t sb[$];

    alu_issue_stage #(.OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_oper_a(req_oper_a), .req_oper_b(req_oper_b),
        .req_use_acc(req_use_acc), .req_acc_wr(req_acc_wr), .req_flag_wr(req_flag_wr),
        .alu_op(alu_op), .alu_oper_a(alu_oper_a), .alu_oper_b(alu_oper_b),
        .alu_flag_carry(alu_flag_carry), .alu_flag_zero(alu_flag_zero),
        .alu_flag_neg(alu_flag_neg), .alu_flag_aux_carry(alu_flag_aux_carry),
        .alu_result(alu_result), .alu_res_carry(alu_res_carry), .alu_res_zero(alu_res_zero),
        .alu_res_neg(alu_res_neg), .alu_res_aux_carry(alu_res_aux_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .acc(acc), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, Z, N, H, C}
    function automatic logic [11:0] alu_ref(input logic [OP_W-1:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
        int r; logic z, n, h, c;
        n = 1'b0; h = 1'b0; c = 1'b0;
        case (int'(op))
            0: begin r = int'(a) + int'(b); h = (int'(a[3:0]) + int'(b[3:0])) > 15; c = r > 255; end
            1: begin r = int'(a) - int'(b); n = 1'b1; h = a[3:0] < b[3:0]; c = a < b; end
            2: begin r = int'(a & b); h = 1'b1; end
            3: r = int'(a | b);
            4: r = int'(a ^ b);
            default: r = int'(b);
        endcase
        z = (r[7:0] == 8'h00);
        return {r[7:0], z, n, h, c};
    endfunction

    // ALU environment driven from the registered operation
    always_comb begin
        {alu_result, alu_res_zero, alu_res_neg, alu_res_aux_carry, alu_res_carry} =
            alu_ref(alu_op, alu_oper_a, alu_oper_b);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete directed transaction with optional back-pressure cycles
    task automatic do_op(input logic [OP_W-1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic aw, input logic fw, input int hold);
        logic [7:0] opa, er;
        logic [3:0] ef;
        logic [7:0] acc_before;
        opa = ua ? m_acc : a;
        {er, ef} = alu_ref(op, opa, b);
        check_val("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_oper_a = a; req_oper_b = b;
        req_use_acc = ua; req_acc_wr = aw; req_flag_wr = fw; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        check_val("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("exec_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("exec_op", {27'd0, alu_op}, {27'd0, op});
        check_val("exec_oper_a", {24'd0, alu_oper_a}, {24'd0, opa});
        check_val("exec_oper_b", {24'd0, alu_oper_b}, {24'd0, b});
        check_val("exec_flag_out", {28'd0, alu_flag_zero, alu_flag_neg, alu_flag_aux_carry, alu_flag_carry},
                  {28'd0, m_flags});
        if (aw) m_acc = er;
        if (fw) m_flags = ef;
        tick();
        check_val("resp_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("resp_result", {24'd0, rsp_result}, {24'd0, er});
        check_val("resp_flags", {28'd0, rsp_flags}, {28'd0, ef});
        check_val("acc", {24'd0, acc}, {24'd0, m_acc});
        check_val("flags", {28'd0, flags}, {28'd0, m_flags});
        acc_before = m_acc;
        for (int i = 0; i < hold; i++) begin
            // A request offered during RESP must be ignored
            req_valid = 1'b1; req_op = '0; req_oper_a = 8'h12; req_oper_b = 8'h34;
            req_use_acc = 1'b0; req_acc_wr = 1'b1; req_flag_wr = 1'b1;
            tick();
            check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("hold_result", {24'd0, rsp_result}, {24'd0, er});
            check_val("hold_flags", {28'd0, rsp_flags}, {28'd0, ef});
            check_val("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("post_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("post_ready", {31'd0, req_ready}, 32'd1);
        check_val("post_acc", {24'd0, acc}, {24'd0, acc_before});
    endtask

    initial begin
        logic [7:0] opa, er;
        logic [3:0] ef;
        int         cyc;
        exp_t       e;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_oper_a = 8'h00; req_oper_b = 8'h00;
        req_use_acc = 1'b0; req_acc_wr = 1'b0; req_flag_wr = 1'b0; rsp_ready = 1'b0;
        m_acc = 8'h00; m_flags = 4'h0;
        tick(); tick();
        check_val("rst_acc", {24'd0, acc}, 32'd0);
        check_val("rst_flags", {28'd0, flags}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check_val("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        check_val("rst_alu_op", {27'd0, alu_op}, 32'd0);
        check_val("rst_alu_a", {24'd0, alu_oper_a}, 32'd0);
        check_val("rst_alu_b", {24'd0, alu_oper_b}, 32'd0);
        rst = 1'b0;
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);

        // ADD 3A+C6 -> 00 with Z,H,C set
        do_op(5'd0, 8'h3A, 8'hC6, 1'b0, 1'b1, 1'b1, 0);
        check_val("add_flags_1011", {28'd0, flags}, 32'hB);
        // Operand A from accumulator (0), flags 1011 visible during EXEC
        do_op(5'd0, 8'hEE, 8'h01, 1'b1, 1'b1, 1'b1, 0);
        // Flag-only write: SUB 56-01 = 55, flags 0100
        do_op(5'd1, 8'h56, 8'h01, 1'b0, 1'b0, 1'b1, 0);
        check_val("sub_flags_0100", {28'd0, flags}, 32'h4);
        // Back-pressure for five cycles
        do_op(5'd4, 8'hA5, 8'h0F, 1'b1, 1'b1, 1'b0, 5);

        // Reset during EXEC of an op producing FF with writeback enabled
        req_valid = 1'b1; req_op = 5'd3; req_oper_a = 8'hF0; req_oper_b = 8'h0F;
        req_use_acc = 1'b0; req_acc_wr = 1'b1; req_flag_wr = 1'b1;
        tick();
        check_val("abort_exec_res", {24'd0, alu_result}, 32'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        m_acc = 8'h00; m_flags = 4'h0;
        check_val("abort_acc", {24'd0, acc}, 32'd0);
        check_val("abort_flags", {28'd0, flags}, 32'd0);
        check_val("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("abort_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check_val("abort_valid2", {31'd0, rsp_valid}, 32'd0);
        check_val("abort_ready2", {31'd0, req_ready}, 32'd1);

        // Randomized phase: decide at each cycle what the next edge will do
        for (cyc = 0; cyc < 3000; cyc++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            req_op      = OP_W'($urandom_range(0, 7));
            req_oper_a  = 8'($urandom);
            req_oper_b  = 8'($urandom);
            req_use_acc = 1'($urandom);
            req_acc_wr  = 1'($urandom);
            req_flag_wr = 1'($urandom);
            rsp_ready   = ($urandom_range(0, 2) != 0);
            if (req_valid && req_ready) begin
                opa = req_use_acc ? m_acc : req_oper_a;
                {er, ef} = alu_ref(req_op, opa, req_oper_b);
                if (req_acc_wr) m_acc = er;
                if (req_flag_wr) m_flags = ef;
                e.res = er; e.rfl = ef; e.acc = m_acc; e.fl = m_flags;
                sb.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_val("rnd_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("rnd_result", {24'd0, rsp_result}, {24'd0, e.res});
                    check_val("rnd_rsp_flags", {28'd0, rsp_flags}, {28'd0, e.rfl});
                    check_val("rnd_acc", {24'd0, acc}, {24'd0, e.acc});
                    check_val("rnd_flags", {28'd0, flags}, {28'd0, e.fl});
                end
            end
            tick();
        end

        // Drain: no new requests, consumer always ready, bounded wait
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (cyc = 0; cyc < 10 && sb.size() != 0; cyc++) begin
            if (rsp_valid) begin
                e = sb.pop_front();
                check_val("drain_result", {24'd0, rsp_result}, {24'd0, e.res});
                check_val("drain_acc", {24'd0, acc}, {24'd0, e.acc});
            end
            tick();
        end
        check_val("drain_pending", sb.size(), 32'd0);
        tick();
        check_val("final_acc", {24'd0, acc}, {24'd0, m_acc});
        check_val("final_flags", {28'd0, flags}, {28'd0, m_flags});
        check_val("final_ready", {31'd0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
